// File: rtl/rs_bra.sv
// Branch reservation station: in-order FIFO of branch/jump uops with CDB operand
// capture; only the head may issue, rollback flushes everything.
module rs_bra_ent #(
  parameter int PTAG_W = 6,
  parameter int ROB_W  = 4,
  parameter int XLEN   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   wr,
  input  logic                   pop,
  input  logic [3:0]             wr_op,
  input  logic [XLEN-1:0]        wr_pc,
  input  logic [XLEN-1:0]        wr_imm,
  input  logic [ROB_W-1:0]       wr_rob_idx,
  input  logic [PTAG_W-1:0]      wr_prd,
  input  logic [1:0][PTAG_W-1:0] wr_tag,
  input  logic [1:0]             wr_rdy,
  input  logic [1:0][XLEN-1:0]   wr_val,
  input  logic                   cdb_valid,
  input  logic [PTAG_W-1:0]      cdb_tag,
  input  logic [XLEN-1:0]        cdb_val,
  output logic                   vld,
  output logic [3:0]             op,
  output logic [XLEN-1:0]        pc,
  output logic [XLEN-1:0]        imm,
  output logic [ROB_W-1:0]       rob_idx,
  output logic [PTAG_W-1:0]      prd,
  output logic [1:0]             rdy,
  output logic [1:0][XLEN-1:0]   val
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0; op <= '0; pc <= '0; imm <= '0; rob_idx <= '0; prd <= '0;
    end else begin
      if (clr)      vld <= 1'b0;
      else if (wr)  vld <= 1'b1;
      else if (pop) vld <= 1'b0;
      if (wr) begin
        op <= wr_op; pc <= wr_pc; imm <= wr_imm; rob_idx <= wr_rob_idx; prd <= wr_prd;
      end
    end
  end

  for (genvar s = 0; s < 2; s++) begin : g_src
    logic [PTAG_W-1:0] tag_q;
    logic              rdy_q;
    logic [XLEN-1:0]   val_q;
    logic              hit_wr, hit_wake;
    // hit_wr covers the producer broadcasting in the very cycle we dispatch
    assign hit_wr   = cdb_valid && !wr_rdy[s] && (cdb_tag == wr_tag[s]);
    assign hit_wake = cdb_valid && vld && !rdy_q && (cdb_tag == tag_q) && !clr;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tag_q <= '0; rdy_q <= 1'b0; val_q <= '0;
      end else if (wr) begin
        tag_q <= wr_tag[s];
        rdy_q <= wr_rdy[s] | hit_wr;
        val_q <= hit_wr ? cdb_val : wr_val[s];
      end else if (hit_wake) begin
        rdy_q <= 1'b1;
        val_q <= cdb_val;
      end
    end
    assign rdy[s] = rdy_q;
    assign val[s] = val_q;
  end
endmodule

module rs_bra #(
  parameter int DEPTH  = 4,
  parameter int PTAG_W = 6,
  parameter int ROB_W  = 4,
  parameter int XLEN   = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rollback,
  input  logic              dp_valid,
  input  logic [3:0]        dp_op,
  input  logic [XLEN-1:0]   dp_pc,
  input  logic [XLEN-1:0]   dp_imm,
  input  logic [ROB_W-1:0]  dp_rob_idx,
  input  logic [PTAG_W-1:0] dp_prd,
  input  logic [PTAG_W-1:0] dp_src1_tag,
  input  logic [PTAG_W-1:0] dp_src2_tag,
  input  logic              dp_src1_rdy,
  input  logic              dp_src2_rdy,
  input  logic [XLEN-1:0]   dp_src1_val,
  input  logic [XLEN-1:0]   dp_src2_val,
  input  logic              cdb_valid,
  input  logic [PTAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]   cdb_val,
  input  logic              issue_ready,
  output logic              full,
  output logic [CW-1:0]     count,
  output logic              issue_valid,
  output logic [3:0]        issue_op,
  output logic [XLEN-1:0]   issue_pc,
  output logic [XLEN-1:0]   issue_imm,
  output logic [ROB_W-1:0]  issue_rob_idx,
  output logic [PTAG_W-1:0] issue_prd,
  output logic [XLEN-1:0]   issue_src1_val,
  output logic [XLEN-1:0]   issue_src2_val
);
  logic [PW-1:0] head, tail;
  logic          acc, pop;

  logic [DEPTH-1:0]                  e_vld;
  logic [DEPTH-1:0][3:0]             e_op;
  logic [DEPTH-1:0][XLEN-1:0]        e_pc, e_imm;
  logic [DEPTH-1:0][ROB_W-1:0]       e_rob;
  logic [DEPTH-1:0][PTAG_W-1:0]      e_prd;
  logic [DEPTH-1:0][1:0]             e_rdy;
  logic [DEPTH-1:0][1:0][XLEN-1:0]   e_val;

  assign full        = (count == CW'(DEPTH));
  assign acc         = dp_valid && !full && !rollback;
  assign issue_valid = (count != '0) && e_vld[head] && (&e_rdy[head]) && !rollback;
  assign pop         = issue_valid && issue_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    rs_bra_ent #(.PTAG_W(PTAG_W), .ROB_W(ROB_W), .XLEN(XLEN)) u_ent (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (rollback),
      .wr         (acc && (tail == PW'(i))),
      .pop        (pop && (head == PW'(i))),
      .wr_op      (dp_op),
      .wr_pc      (dp_pc),
      .wr_imm     (dp_imm),
      .wr_rob_idx (dp_rob_idx),
      .wr_prd     (dp_prd),
      .wr_tag     ({dp_src2_tag, dp_src1_tag}),
      .wr_rdy     ({dp_src2_rdy, dp_src1_rdy}),
      .wr_val     ({dp_src2_val, dp_src1_val}),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_val    (cdb_val),
      .vld        (e_vld[i]),
      .op         (e_op[i]),
      .pc         (e_pc[i]),
      .imm        (e_imm[i]),
      .rob_idx    (e_rob[i]),
      .prd        (e_prd[i]),
      .rdy        (e_rdy[i]),
      .val        (e_val[i])
    );
  end

  assign issue_op       = e_op[head];
  assign issue_pc       = e_pc[head];
  assign issue_imm      = e_imm[head];
  assign issue_rob_idx  = e_rob[head];
  assign issue_prd      = e_prd[head];
  assign issue_src1_val = e_val[head][0];
  assign issue_src2_val = e_val[head][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0; tail <= '0; count <= '0;
    end else if (rollback) begin
      head <= '0; tail <= '0; count <= '0;
    end else begin
      if (acc) tail <= tail + PW'(1);
      if (pop) head <= head + PW'(1);
      count <= count + CW'(acc) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_rs_bra.sv
// Randomized bench for rs_bra: queue-based reference model, per-cycle compare,
// plus directed sequences with literal expectations.
module tb_rs_bra;
  logic        clk = 0, rst_n = 0, rollback = 0, dp_valid = 0;
  logic [3:0]  dp_op = 0, dp_rob_idx = 0;
  logic [31:0] dp_pc = 0, dp_imm = 0, dp_src1_val = 0, dp_src2_val = 0, cdb_val = 0;
  logic [5:0]  dp_prd = 0, dp_src1_tag = 0, dp_src2_tag = 0, cdb_tag = 0;
  logic        dp_src1_rdy = 0, dp_src2_rdy = 0, cdb_valid = 0, issue_ready = 0;
  logic        full, issue_valid;
  logic [2:0]  count;
  logic [3:0]  issue_op, issue_rob_idx;
  logic [31:0] issue_pc, issue_imm, issue_src1_val, issue_src2_val;
  logic [5:0]  issue_prd;

  int checks = 0, failures = 0;

  rs_bra dut (
    .clk(clk), .rst_n(rst_n), .rollback(rollback), .dp_valid(dp_valid), .dp_op(dp_op),
    .dp_pc(dp_pc), .dp_imm(dp_imm), .dp_rob_idx(dp_rob_idx), .dp_prd(dp_prd),
    .dp_src1_tag(dp_src1_tag), .dp_src2_tag(dp_src2_tag), .dp_src1_rdy(dp_src1_rdy),
    .dp_src2_rdy(dp_src2_rdy), .dp_src1_val(dp_src1_val), .dp_src2_val(dp_src2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .issue_ready(issue_ready),
    .full(full), .count(count), .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_pc(issue_pc), .issue_imm(issue_imm), .issue_rob_idx(issue_rob_idx),
    .issue_prd(issue_prd), .issue_src1_val(issue_src1_val), .issue_src2_val(issue_src2_val)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       op;
    logic [31:0]      pc, imm;
    logic [3:0]       rob;
    logic [5:0]       prd;
    logic [1:0][5:0]  tag;
    logic [1:0]       rdy;
    logic [1:0][31:0] val;
  } ent_t;
  ent_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: FIFO of uops, updated at each rising edge from pre-edge inputs
  always @(posedge clk) begin
    ent_t e;
    bit   do_pop, do_acc;
    if (!rst_n || rollback) q.delete();
    else begin
      do_pop = (q.size() > 0) && (q[0].rdy == 2'b11) && issue_ready;
      do_acc = dp_valid && (q.size() < 4);
      for (int i = 0; i < q.size(); i++) begin
        e = q[i];
        for (int s = 0; s < 2; s++)
          if (!e.rdy[s] && cdb_valid && e.tag[s] == cdb_tag) begin
            e.rdy[s] = 1'b1; e.val[s] = cdb_val;
          end
        q[i] = e;
      end
      if (do_pop) q.delete(0);
      if (do_acc) begin
        e.op = dp_op; e.pc = dp_pc; e.imm = dp_imm; e.rob = dp_rob_idx; e.prd = dp_prd;
        e.tag = {dp_src2_tag, dp_src1_tag};
        e.rdy = {dp_src2_rdy, dp_src1_rdy};
        e.val = {dp_src2_val, dp_src1_val};
        for (int s = 0; s < 2; s++)
          if (!e.rdy[s] && cdb_valid && e.tag[s] == cdb_tag) begin
            e.rdy[s] = 1'b1; e.val[s] = cdb_val;
          end
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    bit exp_iv;
    if (rst_n) begin
      exp_iv = (q.size() > 0) && (q[0].rdy == 2'b11) && !rollback;
      chk("m_count", count, q.size());
      chk("m_full", full, q.size() == 4);
      chk("m_issue_valid", issue_valid, exp_iv);
      if (exp_iv) begin
        chk("m_op", issue_op, q[0].op);
        chk("m_pc", issue_pc, q[0].pc);
        chk("m_imm", issue_imm, q[0].imm);
        chk("m_rob", issue_rob_idx, q[0].rob);
        chk("m_prd", issue_prd, q[0].prd);
        chk("m_src1", issue_src1_val, q[0].val[0]);
        chk("m_src2", issue_src2_val, q[0].val[1]);
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic idle();
    dp_valid = 0; cdb_valid = 0; rollback = 0;
  endtask

  task automatic disp(input logic [31:0] pc, input logic [3:0] rob,
                      input logic [5:0] t1, input logic r1, input logic [31:0] v1,
                      input logic [5:0] t2, input logic r2, input logic [31:0] v2);
    dp_valid = 1; dp_pc = pc; dp_rob_idx = rob; dp_op = pc[3:0]; dp_imm = pc + 32'h10;
    dp_prd = pc[7:2]; dp_src1_tag = t1; dp_src1_rdy = r1; dp_src1_val = v1;
    dp_src2_tag = t2; dp_src2_rdy = r2; dp_src2_val = v2;
  endtask

  task automatic cdb(input logic [5:0] t, input logic [31:0] v);
    cdb_valid = 1; cdb_tag = t; cdb_val = v;
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_count", count, 0); chk("rst_full", full, 0); chk("rst_iv", issue_valid, 0);
    chk("rst_pc", issue_pc, 0); chk("rst_src1", issue_src1_val, 0);
    tick(); tick();
    rst_n = 1;
    tick();

    // basic flow
    disp(32'h100, 4'd3, 6'd1, 1, 32'h11, 6'd2, 1, 32'h22);
    tick(); idle();
    chk("basic_iv", issue_valid, 1); chk("basic_pc", issue_pc, 32'h100);
    chk("basic_rob", issue_rob_idx, 3);
    issue_ready = 1;
    tick(); issue_ready = 0;
    chk("basic_count", count, 0);

    // fill, drop, wrap
    for (int k = 0; k < 4; k++) begin
      disp(32'h200 + 32'(k * 4), 4'(k), 6'd1, 1, 32'(k), 6'd2, 1, 32'(k));
      tick();
    end
    idle();
    chk("fill_full", full, 1); chk("fill_count", count, 4);
    disp(32'h999, 4'd9, 6'd1, 1, 0, 6'd2, 1, 0);
    tick(); idle();
    chk("drop_count", count, 4); chk("drop_head", issue_pc, 32'h200);
    issue_ready = 1; tick(); chk("pop1_pc", issue_pc, 32'h204);
    tick(); issue_ready = 0;
    for (int k = 4; k < 6; k++) begin
      disp(32'h200 + 32'(k * 4), 4'(k), 6'd1, 1, 0, 6'd2, 1, 0);
      tick();
    end
    idle(); issue_ready = 1;
    for (int k = 2; k < 6; k++) begin
      chk("wrap_pc", issue_pc, 32'h200 + 32'(k * 4));
      tick();
    end
    issue_ready = 0;
    chk("wrap_empty", count, 0);

    // wakeup
    disp(32'h400, 4'd1, 6'd7, 0, 0, 6'd3, 1, 32'h33);
    tick(); idle();
    chk("wk_iv0", issue_valid, 0);
    cdb(6'd8, 32'hBEEF); tick(); idle();
    chk("wk_miss", issue_valid, 0);
    cdb(6'd7, 32'hDEAD); #1; chk("wk_nobypass", issue_valid, 0);
    tick(); idle();
    chk("wk_iv1", issue_valid, 1); chk("wk_val", issue_src1_val, 32'hDEAD);
    issue_ready = 1; tick(); issue_ready = 0;

    // dispatch-time bypass
    disp(32'h500, 4'd2, 6'd1, 1, 32'h1, 6'd5, 0, 32'h0);
    cdb(6'd5, 32'h42);
    tick(); idle();
    chk("byp_iv", issue_valid, 1); chk("byp_val", issue_src2_val, 32'h42);
    issue_ready = 1; tick(); issue_ready = 0;

    // in-order blocking
    issue_ready = 1;
    disp(32'h600, 4'd4, 6'd9, 0, 0, 6'd1, 1, 0); tick();
    disp(32'h604, 4'd5, 6'd1, 1, 0, 6'd1, 1, 0); tick(); idle();
    chk("ord_block", issue_valid, 0);
    cdb(6'd9, 32'h99); tick(); idle();
    chk("ord_a_iv", issue_valid, 1); chk("ord_a_pc", issue_pc, 32'h600);
    tick();
    chk("ord_b_iv", issue_valid, 1); chk("ord_b_pc", issue_pc, 32'h604);
    tick(); issue_ready = 0;
    chk("ord_empty", count, 0);

    // rollback
    for (int k = 0; k < 3; k++) begin
      disp(32'h700 + 32'(k * 4), 4'(k), 6'd1, 1, 0, 6'd1, 1, 0); tick();
    end
    disp(32'h7F0, 4'd7, 6'd1, 1, 0, 6'd1, 1, 0);
    issue_ready = 1; rollback = 1; #1;
    chk("rb_iv_same", issue_valid, 0);
    tick(); idle();
    chk("rb_count", count, 0); chk("rb_full", full, 0); chk("rb_iv", issue_valid, 0);
    tick(); chk("rb_after", issue_valid, 0);
    issue_ready = 0;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      dp_valid    = ($urandom_range(0, 9) < 6);
      dp_op       = 4'($urandom);
      dp_pc       = $urandom; dp_imm = $urandom;
      dp_rob_idx  = 4'($urandom); dp_prd = 6'($urandom);
      dp_src1_tag = 6'($urandom_range(0, 7)); dp_src2_tag = 6'($urandom_range(0, 7));
      dp_src1_rdy = 1'($urandom); dp_src2_rdy = 1'($urandom);
      dp_src1_val = $urandom; dp_src2_val = $urandom;
      cdb_valid   = 1'($urandom);
      cdb_tag     = 6'($urandom_range(0, 7)); cdb_val = $urandom;
      issue_ready = 1'($urandom);
      rollback    = ($urandom_range(0, 99) < 3);
      tick();
    end
    idle(); issue_ready = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
